// File: rtl/key_pkg.sv
// key_pkg: shared key FSM state encoding and 50 MHz default timing constants
package key_pkg;
  typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, RELEASE_DB} key_st_t;
  localparam int DB_CNT_DEF = 1_000_000;
  localparam int LONG_CNT_DEF = 50_000_000;
endpackage

// File: rtl/key_debounce.sv
// key_debounce: one key's synchroniser, debounce FSM, hold counter and event pulses
module key_debounce
  import key_pkg::*;
#(
  parameter int DB_CNT = DB_CNT_DEF,
  parameter int LONG_CNT = LONG_CNT_DEF
) (
  input  logic sys_clk,
  input  logic sys_res_n,
  input  logic key_in,
  output logic key_state,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse
);
  localparam int CW = $clog2(LONG_CNT);
  localparam logic [CW-1:0] DB_END = CW'(DB_CNT - 1);
  localparam logic [CW-1:0] LONG_END = CW'(LONG_CNT - 1);
  localparam logic [CW-1:0] LONG_PRE = CW'(LONG_CNT - 2);
  logic [1:0] sync;
  logic raw_n, held;
  key_st_t st, st_nx;
  logic [CW-1:0] cnt, cnt_nx, hcnt, hcnt_nx;
  assign raw_n = sync[1];
  assign held = (st == HELD) || (st == RELEASE_DB);
  // pulses are Mealy on the transition so key_state and press_pulse rise together
  assign long_pulse = held && (hcnt == LONG_PRE);
  assign key_state = (held && !release_pulse) || press_pulse;
  always_ff @(posedge sys_clk or negedge sys_res_n)
    if (!sys_res_n) begin
      sync <= '1;
      st <= IDLE;
      cnt <= '0;
      hcnt <= '0;
    end else begin
      sync <= {sync[0], key_in};
      st <= st_nx;
      cnt <= cnt_nx;
      hcnt <= hcnt_nx;
    end
  always_comb begin
    st_nx = st;
    cnt_nx = cnt;
    hcnt_nx = held && (hcnt != LONG_END) ? hcnt + 1'b1 : hcnt;
    press_pulse = 1'b0;
    release_pulse = 1'b0;
    case (st)
      IDLE: if (!raw_n) begin
        st_nx = PRESS_DB;
        cnt_nx = '0;
      end
      PRESS_DB: if (raw_n) st_nx = IDLE;
      else if (cnt == DB_END) begin
        st_nx = HELD;
        press_pulse = 1'b1;
        hcnt_nx = '0;
      end else cnt_nx = cnt + 1'b1;
      HELD: if (raw_n) begin
        st_nx = RELEASE_DB;
        cnt_nx = '0;
      end
      RELEASE_DB: if (!raw_n) st_nx = HELD;
      else if (cnt == DB_END) begin
        st_nx = IDLE;
        release_pulse = 1'b1;
      end else cnt_nx = cnt + 1'b1;
      default: st_nx = IDLE;
    endcase
  end
endmodule

// File: rtl/key_scan.sv
// key_scan: debounced multi-key input with per-key pulses and a registered press encoder
module key_scan
  import key_pkg::*;
#(
  parameter int KEY_W = 4,
  parameter int DB_CNT = DB_CNT_DEF,
  parameter int LONG_CNT = LONG_CNT_DEF
) (
  input  logic                       sys_clk,
  input  logic                       sys_res_n,
  input  logic [KEY_W-1:0]           key_in,
  output logic [KEY_W-1:0]           key_state,
  output logic [KEY_W-1:0]           press_pulse,
  output logic [KEY_W-1:0]           release_pulse,
  output logic [KEY_W-1:0]           long_pulse,
  output logic                       key_valid,
  output logic [$clog2(KEY_W)-1:0]   key_code
);
  localparam int CODE_W = $clog2(KEY_W);
  logic [CODE_W-1:0] low;
  for (genvar i = 0; i < KEY_W; i++) begin : g_key
    key_debounce #(.DB_CNT(DB_CNT), .LONG_CNT(LONG_CNT)) u_db (
      .sys_clk(sys_clk),
      .sys_res_n(sys_res_n),
      .key_in(key_in[i]),
      .key_state(key_state[i]),
      .press_pulse(press_pulse[i]),
      .release_pulse(release_pulse[i]),
      .long_pulse(long_pulse[i])
    );
  end
  always_comb begin
    low = '0;
    for (int i = KEY_W - 1; i >= 0; i--) if (press_pulse[i]) low = CODE_W'(i);
  end
  always_ff @(posedge sys_clk or negedge sys_res_n)
    if (!sys_res_n) begin
      key_valid <= 1'b0;
      key_code <= '0;
    end else begin
      key_valid <= |press_pulse;
      key_code <= |press_pulse ? low : key_code;
    end
endmodule
